// File: rtl/reset_sequencer.sv
// Ordered multi-domain reset release with per-domain ready handshake,
// software reset and sticky ready-timeout flags.
module reset_sequencer #(
    parameter int N_DOM       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYC    = 8,
    parameter int GAP_CYC     = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk,
    input  logic             rst_req,
    input  logic             sw_rst,
    input  logic [N_DOM-1:0] dom_ready,
    output logic [N_DOM-1:0] dom_rst,
    output logic             rst_done,
    output logic [N_DOM-1:0] timeout_err
);

    localparam int SS   = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int MAXA = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
    localparam int MAXL = (MAXA > TIMEOUT_CYC) ? MAXA : TIMEOUT_CYC;
    localparam int CW   = (MAXL > 0) ? $clog2(MAXL + 1) : 1;
    localparam int IW   = (N_DOM > 1) ? $clog2(N_DOM) : 1;

    localparam int HOLD_E = (HOLD_CYC > 0) ? HOLD_CYC - 1 : 0;
    localparam int GAP_E  = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
    localparam int TO_E   = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

    localparam logic [CW-1:0] HOLD_END = CW'(HOLD_E);
    localparam logic [CW-1:0] GAP_END  = CW'(GAP_E);
    localparam logic [CW-1:0] TO_END   = CW'(TO_E);
    localparam logic [IW-1:0] LAST     = IW'(N_DOM - 1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_REL,
        S_WAIT,
        S_GAP,
        S_DONE
    } state_t;

    logic [SS-1:0]    rst_sync_q, rst_sync_d;
    logic             rst_s;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d, cnt_inc;
    logic [IW-1:0]    idx_q, idx_d;
    logic [N_DOM-1:0] dom_rst_q, dom_rst_d;
    logic [N_DOM-1:0] err_q, err_d;
    logic [N_DOM-1:0] rdy_meta_q, rdy_meta_d;
    logic [N_DOM-1:0] rdy_s_q, rdy_s_d;
    logic [N_DOM-1:0] sel_q;
    logic             rdy_cur;

    always_comb begin
        rst_sync_d = {rst_sync_q[SS-2:0], 1'b0};
    end

    always_ff @(posedge clk or posedge rst_req) begin
        if (rst_req) rst_sync_q <= '1;
        else         rst_sync_q <= rst_sync_d;
    end

    assign rst_s = rst_sync_q[SS-1];

    // Ready is only believed once the domain's own reset is deasserted,
    // so a stale acknowledge from a previous run cannot skip the wait.
    always_comb begin
        rdy_meta_d = dom_ready & ~dom_rst_q;
        rdy_s_d    = rdy_meta_q;
    end

    always_comb begin
        sel_q = '0;
        for (int k = 0; k < N_DOM; k++) begin
            if (idx_q == IW'(k)) sel_q[k] = 1'b1;
        end
        rdy_cur = |(rdy_s_q & sel_q);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        dom_rst_d = dom_rst_q;
        err_d     = err_q;
        cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        unique case (state_q)
            S_HOLD: begin
                dom_rst_d = '1;
                if (cnt_q >= HOLD_END) begin
                    state_d = S_REL;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_REL: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (rdy_cur) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else if (cnt_q >= TO_END) begin
                    err_d   = err_q | sel_q;
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_GAP: begin
                if (cnt_q >= GAP_END) begin
                    cnt_d = '0;
                    if (idx_q == LAST) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_REL;
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DONE: begin
                dom_rst_d = '0;
            end
            default: begin
                state_d = S_HOLD;
            end
        endcase
        // The domain is released on the edge that enters REL.
        if (state_d == S_REL) begin
            for (int k = 0; k < N_DOM; k++) begin
                if (idx_d == IW'(k)) dom_rst_d[k] = 1'b0;
            end
        end
        if (sw_rst) begin
            state_d   = S_HOLD;
            cnt_d     = '0;
            idx_d     = '0;
            dom_rst_d = '1;
        end
    end

    always_ff @(posedge clk or posedge rst_s) begin
        if (rst_s) begin
            state_q    <= S_HOLD;
            cnt_q      <= '0;
            idx_q      <= '0;
            dom_rst_q  <= '1;
            err_q      <= '0;
            rdy_meta_q <= '0;
            rdy_s_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            dom_rst_q  <= dom_rst_d;
            err_q      <= err_d;
            rdy_meta_q <= rdy_meta_d;
            rdy_s_q    <= rdy_s_d;
        end
    end

    assign dom_rst     = dom_rst_q;
    assign rst_done    = (state_q == S_DONE);
    assign timeout_err = err_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default 4-domain instance plus
// a single-domain, short-timing instance.
module tb_reset_sequencer;

    logic       clk;
    logic       rst_req, sw_rst;
    logic [3:0] dom_ready, dom_rst, timeout_err;
    logic       rst_done;

    logic       rst_req1, sw_rst1;
    logic [0:0] dom_ready1, dom_rst1, timeout_err1;
    logic       rst_done1;

    int checks = 0;
    int errors = 0;

    reset_sequencer dut (
        .clk(clk), .rst_req(rst_req), .sw_rst(sw_rst),
        .dom_ready(dom_ready), .dom_rst(dom_rst),
        .rst_done(rst_done), .timeout_err(timeout_err)
    );

    reset_sequencer #(
        .N_DOM(1), .HOLD_CYC(1), .GAP_CYC(0)
    ) dut1 (
        .clk(clk), .rst_req(rst_req1), .sw_rst(sw_rst1),
        .dom_ready(dom_ready1), .dom_rst(dom_rst1),
        .rst_done(rst_done1), .timeout_err(timeout_err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected dom_rst given the edge index at which each bit falls.
    function automatic logic [3:0] exp_rst(input int c, input int f0,
                                           input int f1, input int f2,
                                           input int f3);
        logic [3:0] r;
        r[0] = (c < f0);
        r[1] = (c < f1);
        r[2] = (c < f2);
        r[3] = (c < f3);
        return r;
    endfunction

    task automatic test_reset();
        rst_req = 1'b1; sw_rst = 1'b0; dom_ready = 4'b1111;
        rst_req1 = 1'b1; sw_rst1 = 1'b0; dom_ready1 = 1'b1;
        repeat (3) tick();
        checks++;
        if (dom_rst !== 4'b1111) begin
            errors++;
            $display("FAIL reset_dom_rst got %b exp 1111", dom_rst);
        end
        checks++;
        if (rst_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got %b exp 0", rst_done);
        end
        checks++;
        if (timeout_err !== 4'b0000) begin
            errors++;
            $display("FAIL reset_err got %b exp 0000", timeout_err);
        end
        checks++;
        if (dom_rst1 !== 1'b1 || rst_done1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut1 got %b/%b exp 1/0", dom_rst1, rst_done1);
        end
    endtask

    task automatic test_powerup();
        rst_req = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            tick();
            checks++;
            if (dom_rst !== exp_rst(c, 10, 17, 24, 31)) begin
                errors++;
                $display("FAIL powerup_rst c=%0d got %b exp %b", c, dom_rst,
                         exp_rst(c, 10, 17, 24, 31));
            end
            checks++;
            if (rst_done !== (c >= 38)) begin
                errors++;
                $display("FAIL powerup_done c=%0d got %b exp %b", c, rst_done,
                         (c >= 38));
            end
        end
        checks++;
        if (timeout_err !== 4'b0000) begin
            errors++;
            $display("FAIL powerup_err got %b exp 0000", timeout_err);
        end
    endtask

    task automatic test_timeout();
        logic [3:0] ee;
        rst_req = 1'b1; dom_ready = 4'b1011;
        repeat (2) tick();
        rst_req = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            tick();
            ee = (c >= 280) ? 4'b0100 : 4'b0000;
            checks++;
            if (dom_rst !== exp_rst(c, 10, 17, 24, 284)) begin
                errors++;
                $display("FAIL timeout_rst c=%0d got %b exp %b", c, dom_rst,
                         exp_rst(c, 10, 17, 24, 284));
            end
            checks++;
            if (timeout_err !== ee) begin
                errors++;
                $display("FAIL timeout_err c=%0d got %b exp %b", c,
                         timeout_err, ee);
            end
            checks++;
            if (rst_done !== (c >= 291)) begin
                errors++;
                $display("FAIL timeout_done c=%0d got %b exp %b", c, rst_done,
                         (c >= 291));
            end
        end
    endtask

    task automatic test_sw_pulse();
        dom_ready = 4'b1111;
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        checks++;
        if (dom_rst !== 4'b1111 || rst_done !== 1'b0) begin
            errors++;
            $display("FAIL sw_pulse_edge got %b/%b exp 1111/0", dom_rst,
                     rst_done);
        end
        for (int c = 1; c <= 40; c++) begin
            tick();
            checks++;
            if (dom_rst !== exp_rst(c, 8, 15, 22, 29)) begin
                errors++;
                $display("FAIL sw_pulse_rst c=%0d got %b exp %b", c, dom_rst,
                         exp_rst(c, 8, 15, 22, 29));
            end
            checks++;
            if (rst_done !== (c >= 36)) begin
                errors++;
                $display("FAIL sw_pulse_done c=%0d got %b exp %b", c,
                         rst_done, (c >= 36));
            end
            checks++;
            if (timeout_err !== 4'b0100) begin
                errors++;
                $display("FAIL sw_pulse_err c=%0d got %b exp 0100", c,
                         timeout_err);
            end
        end
    endtask

    task automatic test_sw_hold();
        sw_rst = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            checks++;
            if (dom_rst !== 4'b1111 || rst_done !== 1'b0) begin
                errors++;
                $display("FAIL sw_hold c=%0d got %b/%b exp 1111/0", c,
                         dom_rst, rst_done);
            end
        end
        sw_rst = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            checks++;
            if (dom_rst !== exp_rst(c, 8, 15, 22, 29)) begin
                errors++;
                $display("FAIL sw_hold_rel c=%0d got %b exp %b", c, dom_rst,
                         exp_rst(c, 8, 15, 22, 29));
            end
        end
    endtask

    task automatic test_rst_mid();
        #3;
        rst_req = 1'b1;
        #1;
        checks++;
        if (dom_rst !== 4'b1111) begin
            errors++;
            $display("FAIL mid_rst got %b exp 1111", dom_rst);
        end
        checks++;
        if (timeout_err !== 4'b0000) begin
            errors++;
            $display("FAIL mid_err got %b exp 0000", timeout_err);
        end
        checks++;
        if (rst_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_done got %b exp 0", rst_done);
        end
        #1;
        rst_req = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            checks++;
            if (dom_rst !== exp_rst(c, 10, 17, 24, 31)) begin
                errors++;
                $display("FAIL mid_restart c=%0d got %b exp %b", c, dom_rst,
                         exp_rst(c, 10, 17, 24, 31));
            end
        end
    endtask

    task automatic test_sweep();
        rst_req1 = 1'b0;
        for (int c = 1; c <= 300; c++) begin
            tick();
            checks++;
            if (dom_rst1 !== 1'((c < 3) ? 1 : 0)) begin
                errors++;
                $display("FAIL sweep_rst c=%0d got %b exp %b", c, dom_rst1,
                         (c < 3));
            end
            checks++;
            if (rst_done1 !== (c >= 7)) begin
                errors++;
                $display("FAIL sweep_done c=%0d got %b exp %b", c, rst_done1,
                         (c >= 7));
            end
            checks++;
            if (timeout_err1 !== 1'b0) begin
                errors++;
                $display("FAIL sweep_err c=%0d got %b exp 0", c, timeout_err1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_timeout();
        test_sw_pulse();
        test_sw_hold();
        test_rst_mid();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 The block SHALL have parameter N_DOM, default 4, number of reset domains sequenced.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, depth of the internal rst_req deassertion synchronizer (minimum 2).
REQ-003 The block SHALL have parameter HOLD_CYC, default 8, clk cycles for which all domains stay in reset after synchronized release.
REQ-004 The block SHALL have parameter GAP_CYC, default 4, clk cycles between a domain becoming ready and release of the next domain.
REQ-005 The block SHALL have parameter TIMEOUT_CYC, default 255, maximum clk cycles to wait for a domain ready before flagging an error.
REQ-006 The block SHALL have port clk, input, 1 bit, the sequencer clock.
REQ-007 The block SHALL have port rst_req, input, 1 bit, reset, asynchronous, active-high.
REQ-008 The block SHALL have port sw_rst, input, 1 bit, synchronous to clk, software reset request, active-high.
REQ-009 The block SHALL have port dom_ready, input, N_DOM bits, per-domain "out of reset" acknowledge, asynchronous to clk.
REQ-010 The block SHALL have port dom_rst, output, N_DOM bits, per-domain reset, active-high, registered.
REQ-011 The block SHALL have port rst_done, output, 1 bit, high when all domains are released.
REQ-012 The block SHALL have port timeout_err, output, N_DOM bits, sticky per-domain ready timeout flags.

Function
REQ-013 The block SHALL contain an internal SYNC_STAGES-flop reset synchronizer: asserts asynchronously with rst_req, releases SYNC_STAGES clk edges after rst_req falls; all other flops SHALL be reset by its output.
REQ-014 The block SHALL pass each dom_ready bit through a 2-flop synchronizer before use; the FSM SHALL see only the synchronized value (rdy_s).
REQ-015 The FSM SHALL have the states HOLD, REL, WAIT, GAP and DONE, with HOLD as the reset state.
REQ-016 In HOLD the block SHALL hold dom_rst all ones, count HOLD_CYC cycles, then go to REL with index i=0.
REQ-017 In REL the block SHALL clear dom_rst[i] on that edge, clear the wait counter, and go to WAIT next cycle.
REQ-018 In WAIT, when rdy_s[i]=1, the block SHALL go to GAP.
REQ-019 In WAIT, when the wait counter reaches TIMEOUT_CYC with rdy_s[i]=0, the block SHALL set timeout_err[i] and go to GAP.
REQ-020 In GAP the block SHALL count GAP_CYC cycles; then, if i=N_DOM-1, go to DONE, else set i=i+1 and go to REL.
REQ-021 In DONE the block SHALL drive rst_done=1 and hold dom_rst all zeros until sw_rst or rst_req.
REQ-022 The block SHALL release domains strictly in index order 0..N_DOM-1, and each released domain SHALL stay released until a reset event.
REQ-023 When sw_rst=1 at a clk edge in any state, the block SHALL set dom_rst all ones and rst_done=0 on that edge, clear all counters and i, and enter HOLD; sw_rst held high SHALL keep the block in HOLD with counter at 0.
REQ-024 sw_rst SHALL NOT clear timeout_err.
REQ-025 Counters SHALL be sized for ceil(log2(max+1)) of their limit, SHALL saturate and never wrap, and i SHALL be sized ceil(log2(N_DOM)), minimum 1 bit.
REQ-026 rst_done SHALL be 1 only in DONE.
REQ-027 A rdy_s[i] drop after i has advanced SHALL be ignored.

Reset
REQ-028 While rst_req=1 (asynchronous, no clk needed), the block SHALL hold dom_rst all ones, rst_done=0, timeout_err all zeros, FSM in HOLD, and all counters and i at 0.
REQ-029 When rst_req asserts mid-sequence, the block SHALL re-assert all dom_rst immediately and restart the full sequence after release.

Verification
REQ-030 The bench SHALL cover power-up with defaults: drop rst_req, dom_ready all ones -> dom_rst[0] falls 2+8 edges later; each next bit falls 1+2+4 cycles after the previous (REL, rdy sync, GAP); rst_done=1 after the last GAP; timeout_err=0.
REQ-031 The bench SHALL cover timeout: dom_ready[2] tied 0 -> timeout_err[2]=1 after 255 WAIT cycles, domain 3 still released, rst_done=1.
REQ-032 The bench SHALL cover a 1-cycle sw_rst pulse in DONE: dom_rst=4'b1111 and rst_done=0 on the next edge, then a full resequence, with timeout_err kept.
REQ-033 The bench SHALL cover a rst_req pulse between clk edges while in WAIT for i=1: dom_rst=4'b1111 immediately and timeout_err cleared.
REQ-034 The bench SHALL cover a sweep with N_DOM=1, HOLD_CYC=1, GAP_CYC=0: a single release, after which rst_done asserts with no counter wrap.
